// File: rtl/qspi_cmd_seq_pkg.sv
// Shared types and word formatting for the QSPI command sequencer.
// Holds command opcodes, the FSM state and address-mode enums, the registered descriptor struct,
// the successor-state function and the command-word formatter.
package qspi_cmd_pkg;

  // SPI-master command opcodes, placed in bits [31:28] of every command word
  localparam logic [3:0] OP_CFG      = 4'h0;
  localparam logic [3:0] OP_SOT      = 4'h1;
  localparam logic [3:0] OP_SEND_CMD = 4'h2;
  localparam logic [3:0] OP_DUMMY    = 4'h4;
  localparam logic [3:0] OP_TX_DATA  = 4'h6;
  localparam logic [3:0] OP_RX_DATA  = 4'h7;
  localparam logic [3:0] OP_EOT      = 4'h9;

  // Internal storage widths. The length is zero-extended to the 16-bit word field.
  // The dummy count is kept at the 5-bit width of the word field.
  localparam int DESC_LEN_W   = 16;
  localparam int DESC_DUMMY_W = 5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG,
    ST_SOT,
    ST_OPC,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DUMMY,
    ST_DATA,
    ST_EOT
  } state_e;

  typedef enum logic [1:0] {
    AM_NONE = 2'd0,
    AM_24   = 2'd1,
    AM_32   = 2'd2,
    AM_RSVD = 2'd3
  } amode_e;

  typedef struct packed {
    logic                    cpol;
    logic                    cpha;
    logic [7:0]              clkdiv;
    logic [1:0]              cs;
    logic                    qpi;
    logic [7:0]              opc;
    amode_e                  amode;
    logic [31:0]             addr;
    logic [DESC_DUMMY_W-1:0] dummy;
    logic [DESC_LEN_W-1:0]   len;
    logic                    rx;
  } qspi_desc_t;

  // The reserved address mode behaves like "no address".
  function automatic logic has_addr(input qspi_desc_t d);
    return (d.amode == AM_24) || (d.amode == AM_32);
  endfunction

  // State that follows st once its word has been handshaken; optional phases are skipped.
  function automatic state_e next_state(input state_e st, input qspi_desc_t d);
    state_e after_addr;
    state_e nxt;
    if (d.dummy != '0)
      after_addr = ST_DUMMY;
    else if (d.len != '0)
      after_addr = ST_DATA;
    else
      after_addr = ST_EOT;

    case (st)
      ST_CFG:     nxt = ST_SOT;
      ST_SOT:     nxt = ST_OPC;
      ST_OPC:     nxt = has_addr(d) ? ST_ADDR_HI : after_addr;
      ST_ADDR_HI: nxt = ST_ADDR_LO;
      ST_ADDR_LO: nxt = after_addr;
      ST_DUMMY:   nxt = (d.len != '0) ? ST_DATA : ST_EOT;
      ST_DATA:    nxt = ST_EOT;
      default:    nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

  // Command word emitted while the FSM sits in st.
  // SEND_CMD values are left-aligned in [15:0] and sent MSB-first.
  function automatic logic [31:0] fmt_word(input state_e st, input qspi_desc_t d,
                                           input logic eot_evt);
    logic [31:0]           w;
    logic [DESC_DUMMY_W-1:0] dm1;
    logic [DESC_LEN_W-1:0]   lm1;
    dm1 = d.dummy - DESC_DUMMY_W'(1);
    lm1 = d.len - DESC_LEN_W'(1);
    case (st)
      ST_CFG:     w = {OP_CFG, 18'b0, d.cpol, d.cpha, d.clkdiv};
      ST_SOT:     w = {OP_SOT, 26'b0, d.cs};
      ST_OPC:     w = {OP_SEND_CMD, d.qpi, 7'b0, 4'd7, d.opc, 8'h00};
      ST_ADDR_HI: w = (d.amode == AM_24) ?
                      {OP_SEND_CMD, d.qpi, 7'b0, 4'd15, d.addr[23:8]} :
                      {OP_SEND_CMD, d.qpi, 7'b0, 4'd15, d.addr[31:16]};
      ST_ADDR_LO: w = (d.amode == AM_24) ?
                      {OP_SEND_CMD, d.qpi, 7'b0, 4'd7, d.addr[7:0], 8'h00} :
                      {OP_SEND_CMD, d.qpi, 7'b0, 4'd15, d.addr[15:0]};
      ST_DUMMY:   w = {OP_DUMMY, 7'b0, dm1, 16'b0};
      ST_DATA:    w = {(d.rx ? OP_RX_DATA : OP_TX_DATA), d.qpi, 11'b0, lm1};
      ST_EOT:     w = {OP_EOT, 27'b0, eot_evt};
      default:    w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/qspi_cmd_seq_if.sv
// Descriptor and command channels of the QSPI command sequencer.
// The descriptor channel runs from software/uDMA to the sequencer; the command channel runs from the sequencer to the SPI-master core.
// slave = the sequencer side, master = the side that drives descriptors and consumes words.
interface qspi_cmd_seq_if #(
  parameter int LEN_W   = 16,
  parameter int DUMMY_W = 5
);
  logic               desc_valid_i;
  logic               desc_ready_o;
  logic [9:0]         desc_cfg_i;
  logic [1:0]         desc_cs_i;
  logic               desc_qpi_i;
  logic [7:0]         desc_opc_i;
  logic [1:0]         desc_amode_i;
  logic [31:0]        desc_addr_i;
  logic [DUMMY_W-1:0] desc_dummy_i;
  logic [LEN_W-1:0]   desc_len_i;
  logic               desc_rx_i;
  logic [31:0]        cmd_o;
  logic               cmd_valid_o;
  logic               cmd_ready_i;

  modport slave (
    input  desc_valid_i, desc_cfg_i, desc_cs_i, desc_qpi_i, desc_opc_i, desc_amode_i,
           desc_addr_i, desc_dummy_i, desc_len_i, desc_rx_i, cmd_ready_i,
    output desc_ready_o, cmd_o, cmd_valid_o
  );

  modport master (
    output desc_valid_i, desc_cfg_i, desc_cs_i, desc_qpi_i, desc_opc_i, desc_amode_i,
           desc_addr_i, desc_dummy_i, desc_len_i, desc_rx_i, cmd_ready_i,
    input  desc_ready_o, cmd_o, cmd_valid_o
  );
endinterface

// File: rtl/qspi_cmd_seq.sv
// Purpose: expands one flash descriptor into the ordered 32-bit SPI-master command words.
// Latency: the first word is valid the cycle after accept. One word per cycle follows, and done_o comes one cycle after EOT.
// Backpressure: cmd_o/cmd_valid_o are registered and hold while cmd_ready_i is low; no new descriptor is taken until IDLE.
// Ports: sys_clk_i/rstn_i clock and async active-low reset, clr_i synchronous flush,
//        bus (descriptor in, command out), busy_o while a descriptor is active, done_o completion pulse.
module qspi_cmd_seq
  import qspi_cmd_pkg::*;
#(
  parameter int   LEN_W   = 16,
  parameter int   DUMMY_W = 5,
  parameter logic EOT_EVT = 1'b1
) (
  input  logic           sys_clk_i,
  input  logic           rstn_i,
  input  logic           clr_i,
  qspi_cmd_seq_if.slave  bus,
  output logic           busy_o,
  output logic           done_o
);

  state_e     state_q, state_d;
  qspi_desc_t desc_q, desc_in, fmt_src;
  logic [31:0] cmd_q, cmd_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        done_q, done_d;
  logic        accept, hs;

  logic [LEN_W-1:0]   len_in;
  logic [DUMMY_W-1:0] dummy_in;

  assign len_in   = bus.desc_len_i;
  assign dummy_in = bus.desc_dummy_i;

  always_comb begin
    desc_in        = '0;
    desc_in.cpol   = bus.desc_cfg_i[9];
    desc_in.cpha   = bus.desc_cfg_i[8];
    desc_in.clkdiv = bus.desc_cfg_i[7:0];
    desc_in.cs     = bus.desc_cs_i;
    desc_in.qpi    = bus.desc_qpi_i;
    desc_in.opc    = bus.desc_opc_i;
    desc_in.amode  = amode_e'(bus.desc_amode_i);
    desc_in.addr   = bus.desc_addr_i;
    desc_in.dummy  = DESC_DUMMY_W'(dummy_in);
    desc_in.len    = DESC_LEN_W'(len_in);
    desc_in.rx     = bus.desc_rx_i;
  end

  assign bus.desc_ready_o = (state_q == ST_IDLE);
  assign accept           = bus.desc_valid_i & bus.desc_ready_o;
  assign hs               = cmd_valid_q & bus.cmd_ready_i;

  // State register
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Next state: the state names the word currently presented on cmd_o
  always_comb begin
    state_d = state_q;
    if (clr_i)
      state_d = ST_IDLE;
    else if (state_q == ST_IDLE) begin
      if (bus.desc_valid_i)
        state_d = ST_CFG;
    end else if (hs)
      state_d = next_state(state_q, desc_q);
  end

  // Output next values. The word for the next state is formatted one cycle early so it can be registered.
  // On accept, the descriptor register is not loaded yet, so format from the live inputs.
  always_comb begin
    fmt_src     = (state_q == ST_IDLE) ? desc_in : desc_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    done_d      = 1'b0;
    if (clr_i) begin
      cmd_d       = '0;
      cmd_valid_d = 1'b0;
    end else if (state_d != state_q) begin
      cmd_valid_d = (state_d != ST_IDLE);
      cmd_d       = (state_d != ST_IDLE) ? fmt_word(state_d, fmt_src, EOT_EVT) : '0;
      done_d      = (state_q == ST_EOT);
    end
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      done_q      <= 1'b0;
      desc_q      <= '0;
    end else begin
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      done_q      <= done_d;
      if (clr_i)
        desc_q <= '0;
      else if (accept)
        desc_q <= desc_in;
    end
  end

  assign bus.cmd_o       = cmd_q;
  assign bus.cmd_valid_o = cmd_valid_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = done_q;

endmodule
